// File: rtl/icache_line_fill_pkg.sv
// Shared constants and types for the instruction-cache line-fill controller.
package icache_line_fill_pkg;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int LINE_WORDS = 16;
    localparam int LINE_BITS  = 512;
    localparam int OFFSET_W   = 4;
    localparam int BYTE_OFF_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/icache_line_fill_if.sv
// Line-fill bus between the cache (master) and the instruction memory (slave).
interface icache_line_fill_if;
    import icache_line_fill_pkg::*;

    logic                 mem_req;
    logic [ADDR_W-1:0]    mem_addr;
    logic [LINE_BITS-1:0] mem_rdata;
    logic                 mem_ready;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/icache_tag_store.sv
// Valid/tag/data arrays: one synchronous write port, one combinational read port.
module icache_tag_store
    import icache_line_fill_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = 3,
    parameter int TAG_W     = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 invalidate,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [LINE_BITS-1:0] wr_data,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    // Valid bits: invalidate clears every line, but a same-cycle fill still marks its own line valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            // NOTE: non-blocking assignment, so the later per-line set overrides the bulk clear in the same edge.
            if (invalidate) valid_q <= '0;
            if (wr_en)      valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: written only by a completed fill.
    // NOTE: deliberately no reset here; the valid bit alone guards these contents and RAM macros cannot be reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_line_fill.sv
// Direct-mapped instruction cache: combinational hit path, line fill on miss, abort on redirect.
module icache_line_fill
    import icache_line_fill_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic                        cpu_req,
    input  logic                        redirect,
    input  logic                        invalidate,
    output logic [WORD_W-1:0]           instr,
    output logic                        hit,
    output logic                        miss_stall,
    icache_line_fill_if.master          mem,
    output logic [31:0]                 hit_cnt,
    output logic [31:0]                 miss_cnt
);

    localparam int TAG_W = ADDR_W - BYTE_OFF_W - IDX_W;

    logic [OFFSET_W-1:0]  cpu_offset;
    logic [IDX_W-1:0]     cpu_index;
    logic [TAG_W-1:0]     cpu_tag;
    logic                 unused_addr_bits;

    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_data;

    state_t               state_q, state_d;
    logic                 start_fill;
    logic                 exit_fill;
    logic                 fill_we;
    logic [IDX_W-1:0]     fill_idx_q;
    logic [TAG_W-1:0]     fill_tag_q;

    assign cpu_offset       = cpu_addr[BYTE_OFF_W-1:2];
    assign cpu_index        = cpu_addr[BYTE_OFF_W+IDX_W-1:BYTE_OFF_W];
    assign cpu_tag          = cpu_addr[ADDR_W-1:BYTE_OFF_W+IDX_W];
    assign unused_addr_bits = ^cpu_addr[1:0];

    icache_tag_store #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_store (
        .clk        (clk),
        .reset      (reset),
        .invalidate (invalidate),
        .wr_en      (fill_we),
        .wr_idx     (fill_idx_q),
        .wr_tag     (fill_tag_q),
        .wr_data    (mem.mem_rdata),
        .rd_idx     (cpu_index),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data)
    );

    assign hit        = cpu_req && rd_valid && (rd_tag == cpu_tag);
    assign miss_stall = cpu_req && !hit;
    assign instr      = hit ? rd_data[{cpu_offset, 5'b0} +: WORD_W] : '0;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: start a fill on a clean miss, leave FILL on redirect (discard) or mem_ready (write).
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        start_fill = 1'b0;
        exit_fill  = 1'b0;
        fill_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req && !hit && !redirect) begin
                    state_d    = FILL;
                    start_fill = 1'b1;
                end
            end
            FILL: begin
                if (redirect) begin
                    state_d   = IDLE;
                    exit_fill = 1'b1;
                end else if (mem.mem_ready) begin
                    state_d   = IDLE;
                    exit_fill = 1'b1;
                    fill_we   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fill request registers: latch the line address and destination when a fill starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            fill_idx_q   <= '0;
            fill_tag_q   <= '0;
        end else if (start_fill) begin
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= {cpu_addr[ADDR_W-1:BYTE_OFF_W], {BYTE_OFF_W{1'b0}}};
            fill_idx_q   <= cpu_index;
            fill_tag_q   <= cpu_tag;
        end else if (exit_fill) begin
            mem.mem_req  <= 1'b0;
        end
    end

    // Saturating performance counters: hit cycles and fills started.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit && (hit_cnt != '1))         hit_cnt  <= hit_cnt + 32'd1;
            if (start_fill && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
        end
    end

endmodule
